// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the MIPS decode-stage control logic:
//   - opcode and funct encodings
//   - reg_dst_t : which instruction field names the destination register
//   - ctrl_t    : the decoded control bundle carried into ID/EX
//   - CTRL_BUBBLE : the all-zero bundle used for bubbles
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Opcodes
    localparam int ROP  = 'h00;
    localparam int J    = 'h02;
    localparam int JAL  = 'h03;
    localparam int BEQ  = 'h04;
    localparam int ADDI = 'h08;
    localparam int LW   = 'h23;
    localparam int SW   = 'h2B;
    localparam int LWR  = 'h30;

    // R-type funct codes
    localparam int MULT = 'h18;
    localparam int MFHI = 'h10;
    localparam int MFLO = 'h12;
    localparam int ADD  = 'h20;

    // Destination select; RA means the link register (31)
    typedef enum logic [1:0] {
        RT = 2'd0,
        RD = 2'd1,
        RA = 2'd2
    } reg_dst_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        reg_dst_t   reg_dst;
        logic       ext_op;
        logic       jump;
        logic       branch;
        logic       is_mult;
        logic       hilo_read;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decoder.sv
// ---------------------------------------------------------------------------
// control_decoder
// Purely combinational opcode/funct decoder.
// Ports:
//   op_code  in  OP_BITS     instruction opcode
//   funct    in  FUNCT_BITS  R-type funct field
//   ctrl     out ctrl_t      decoded control bundle (bubble for unknown ops)
//   illegal  out 1           opcode not recognised
// ---------------------------------------------------------------------------
module control_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_BITS    = 6,
    parameter int FUNCT_BITS = 6
) (
    input  logic [OP_BITS-1:0]    op_code,
    input  logic [FUNCT_BITS-1:0] funct,
    output ctrl_t                 ctrl,
    output logic                  illegal
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        case (op_code)
            OP_BITS'(ROP): begin
                ctrl.reg_dst   = RD;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 2'b10;
                if (funct == FUNCT_BITS'(MULT)) begin
                    // MULT writes HI/LO, not the register file
                    ctrl.reg_write = 1'b0;
                    ctrl.alu_op    = 2'b11;
                    ctrl.is_mult   = 1'b1;
                end
                if (funct == FUNCT_BITS'(MFHI) || funct == FUNCT_BITS'(MFLO)) begin
                    ctrl.hilo_read = 1'b1;
                end
            end
            OP_BITS'(LW): begin
                ctrl.reg_dst    = RT;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 2'b01;
                ctrl.reg_write  = 1'b1;
                ctrl.ext_op     = 1'b1;
            end
            OP_BITS'(SW): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.ext_op    = 1'b1;
            end
            OP_BITS'(BEQ): begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = 2'b01;
                ctrl.ext_op = 1'b1;
            end
            OP_BITS'(ADDI): begin
                ctrl.reg_dst   = RT;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.ext_op    = 1'b1;
            end
            OP_BITS'(J): begin
                ctrl.jump = 1'b1;
            end
            OP_BITS'(JAL): begin
                ctrl.jump       = 1'b1;
                ctrl.reg_dst    = RA;
                ctrl.mem_to_reg = 2'b10;
                ctrl.reg_write  = 1'b1;
            end
            OP_BITS'(LWR): begin
                ctrl.reg_dst    = RD;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 2'b01;
                ctrl.reg_write  = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_control_stage.sv
// ---------------------------------------------------------------------------
// decode_control_stage
// Decode-stage control for the 5-stage MIPS pipeline: decodes the IF/ID
// instruction, detects load-use and multiply-busy hazards, and owns the
// ID/EX control register, the multiply occupancy counter and a sticky
// illegal-opcode flag.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid_d                     IF/ID holds a valid instruction
//   op_code_d, funct_d             opcode / funct fields
//   rs_d, rt_d, rd_d               register fields
//   flush_d                        decode instruction is killed
//   ext_op_d, jump_d, branch_d     combinational decode controls
//   stall_f, stall_d               hold PC / IF/ID
//   reg_write_e .. alu_op_e, dst_e registered EX controls
//   mult_busy                      multiplier occupied
//   illegal_op                     sticky unknown-opcode flag
// ---------------------------------------------------------------------------
module decode_control_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_BITS       = 6,
    parameter int FUNCT_BITS    = 6,
    parameter int REG_ADDR_BITS = 5,
    parameter int MULT_CYCLES   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_d,
    input  logic [OP_BITS-1:0]       op_code_d,
    input  logic [FUNCT_BITS-1:0]    funct_d,
    input  logic [REG_ADDR_BITS-1:0] rs_d,
    input  logic [REG_ADDR_BITS-1:0] rt_d,
    input  logic [REG_ADDR_BITS-1:0] rd_d,
    input  logic                     flush_d,
    output logic                     ext_op_d,
    output logic                     jump_d,
    output logic                     branch_d,
    output logic                     stall_f,
    output logic                     stall_d,
    output logic                     reg_write_e,
    output logic                     mem_write_e,
    output logic                     mem_read_e,
    output logic                     alu_src_e,
    output logic [1:0]               mem_to_reg_e,
    output logic [1:0]               alu_op_e,
    output logic [REG_ADDR_BITS-1:0] dst_e,
    output logic                     mult_busy,
    output logic                     illegal_op
);

    localparam int CNT_W = $clog2(MULT_CYCLES + 1);

    ctrl_t                     dec;
    ctrl_t                     ctrl_d;
    logic                      dec_illegal;
    logic                      live;
    logic                      illegal_d;
    logic                      load_use;
    logic                      mult_hazard;
    logic                      stall;
    logic                      bubble;
    logic [REG_ADDR_BITS-1:0]  dst_d;
    logic [CNT_W-1:0]          mult_count;

    control_decoder #(
        .OP_BITS   (OP_BITS),
        .FUNCT_BITS(FUNCT_BITS)
    ) u_decoder (
        .op_code(op_code_d),
        .funct  (funct_d),
        .ctrl   (dec),
        .illegal(dec_illegal)
    );

    // An empty IF/ID slot decodes as a bubble
    assign ctrl_d    = in_valid_d ? dec : CTRL_BUBBLE;
    assign illegal_d = in_valid_d & dec_illegal;

    assign ext_op_d = ctrl_d.ext_op;
    assign jump_d   = ctrl_d.jump;
    assign branch_d = ctrl_d.branch;

    // Hazards only matter for an instruction that will actually proceed
    assign live = in_valid_d & ~flush_d;

    // Conservative: compares both rs and rt regardless of operand usage
    assign load_use = live & mem_read_e & (dst_e != '0)
                      & ((dst_e == rs_d) | (dst_e == rt_d));
    assign mult_hazard = live & mult_busy & (ctrl_d.is_mult | ctrl_d.hilo_read);
    assign stall       = load_use | mult_hazard;

    assign stall_f = stall;
    assign stall_d = stall;

    assign bubble = ~in_valid_d | flush_d | stall | illegal_d;

    always_comb begin
        case (ctrl_d.reg_dst)
            RD:      dst_d = rd_d;
            RA:      dst_d = REG_ADDR_BITS'(31);
            default: dst_d = rt_d;
        endcase
    end

    assign mult_busy = (mult_count != '0);

    // ID/EX register, multiply counter and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_e  <= 1'b0;
            mem_write_e  <= 1'b0;
            mem_read_e   <= 1'b0;
            alu_src_e    <= 1'b0;
            mem_to_reg_e <= 2'b00;
            alu_op_e     <= 2'b00;
            dst_e        <= '0;
            mult_count   <= '0;
            illegal_op   <= 1'b0;
        end else begin
            if (bubble) begin
                reg_write_e  <= 1'b0;
                mem_write_e  <= 1'b0;
                mem_read_e   <= 1'b0;
                alu_src_e    <= 1'b0;
                mem_to_reg_e <= 2'b00;
                alu_op_e     <= 2'b00;
                dst_e        <= '0;
            end else begin
                reg_write_e  <= ctrl_d.reg_write;
                mem_write_e  <= ctrl_d.mem_write;
                mem_read_e   <= ctrl_d.mem_read;
                alu_src_e    <= ctrl_d.alu_src;
                mem_to_reg_e <= ctrl_d.mem_to_reg;
                alu_op_e     <= ctrl_d.alu_op;
                dst_e        <= dst_d;
            end

            // Only a MULT that really enters EX occupies the multiplier
            if (!bubble && ctrl_d.is_mult) begin
                mult_count <= CNT_W'(MULT_CYCLES);
            end else if (mult_count != '0) begin
                mult_count <= mult_count - CNT_W'(1);
            end

            if (live && !stall && illegal_d) begin
                illegal_op <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_control_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_control_stage
// Directed and randomized stimulus against a behavioural model of the
// decode-stage control block (MULT_CYCLES = 4).
// ---------------------------------------------------------------------------
module tb_decode_control_stage;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid_d = 1'b0;
    logic [5:0] op_code_d = '0;
    logic [5:0] funct_d = '0;
    logic [4:0] rs_d = '0, rt_d = '0, rd_d = '0;
    logic       flush_d = 1'b0;
    logic       ext_op_d, jump_d, branch_d, stall_f, stall_d;
    logic       reg_write_e, mem_write_e, mem_read_e, alu_src_e;
    logic [1:0] mem_to_reg_e, alu_op_e;
    logic [4:0] dst_e;
    logic       mult_busy, illegal_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_control_stage #(
        .OP_BITS(6), .FUNCT_BITS(6), .REG_ADDR_BITS(5), .MULT_CYCLES(MC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_d(in_valid_d),
        .op_code_d(op_code_d), .funct_d(funct_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .flush_d(flush_d),
        .ext_op_d(ext_op_d), .jump_d(jump_d), .branch_d(branch_d),
        .stall_f(stall_f), .stall_d(stall_d),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .mem_read_e(mem_read_e), .alu_src_e(alu_src_e),
        .mem_to_reg_e(mem_to_reg_e), .alu_op_e(alu_op_e),
        .dst_e(dst_e), .mult_busy(mult_busy), .illegal_op(illegal_op)
    );

    // Expected effect of one instruction, straight from the decode table
    typedef struct packed {
        logic       rw, mw, mr, as;
        logic [1:0] m2r, aop;
        logic [4:0] dst;
        logic       ext, jmp, br, mult, hilo, ill;
    } exp_t;

    exp_t m_ex   = '0;   // what EX should hold
    int   m_busy = 0;    // multiplier cycles still outstanding
    bit   m_ill  = 0;
    bit   last_stall = 0;
    int   dut_stalls = 0;

    function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] rt, input logic [4:0] rd);
        exp_t e;
        e = '0;
        e.dst = rt;
        case (op)
            6'h00: begin
                e.rw = 1; e.aop = 2'd2; e.dst = rd;
                if (fn == 6'h18) begin e.rw = 0; e.aop = 2'd3; e.mult = 1; end
                if (fn == 6'h10 || fn == 6'h12) e.hilo = 1;
            end
            6'h23: begin e.as = 1; e.mr = 1; e.m2r = 2'd1; e.rw = 1; e.ext = 1; end
            6'h2B: begin e.as = 1; e.mw = 1; e.ext = 1; end
            6'h04: begin e.br = 1; e.aop = 2'd1; e.ext = 1; end
            6'h08: begin e.as = 1; e.rw = 1; e.ext = 1; end
            6'h02: begin e.jmp = 1; end
            6'h03: begin e.jmp = 1; e.dst = 5'd31; e.m2r = 2'd2; e.rw = 1; end
            6'h30: begin e.dst = rd; e.mr = 1; e.m2r = 2'd1; e.rw = 1; end
            default: begin e = '0; e.ill = 1; end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_ex(input string pfx);
        check({pfx, "ex_bundle"},
              {3'b0, reg_write_e, mem_write_e, mem_read_e, alu_src_e, mem_to_reg_e, alu_op_e, dst_e},
              {3'b0, m_ex.rw, m_ex.mw, m_ex.mr, m_ex.as, m_ex.m2r, m_ex.aop, m_ex.dst});
        check({pfx, "mult_busy"}, 16'(mult_busy), 16'(m_busy > 0));
        check({pfx, "illegal_op"}, 16'(illegal_op), 16'(m_ill));
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // advance the model across the rising edge and check registered outputs.
    task automatic step(input bit v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input bit fl);
        exp_t d;
        bit lu, mh, st, bub;
        in_valid_d = v; op_code_d = op; funct_d = fn;
        rs_d = rs; rt_d = rt; rd_d = rd; flush_d = fl;
        #1;
        d = '0;
        if (v) d = ref_decode(op, fn, rt, rd);
        lu = v && !fl && m_ex.mr && (m_ex.dst != 0) && (m_ex.dst == rs || m_ex.dst == rt);
        mh = v && !fl && (m_busy > 0) && (d.mult || d.hilo);
        st = lu || mh;
        last_stall = st;
        if (stall_d === 1'b1) dut_stalls++;
        check("stall_f", 16'(stall_f), 16'(st));
        check("stall_d", 16'(stall_d), 16'(st));
        check("dec_ctl", {13'b0, ext_op_d, jump_d, branch_d}, {13'b0, d.ext, d.jmp, d.br});
        @(posedge clk);
        bub = !v || fl || st || d.ill;
        if (!bub && d.mult) m_busy = MC;
        else if (m_busy > 0) m_busy--;
        if (bub) m_ex = '0; else m_ex = d;
        if (v && !fl && !st && d.ill) m_ill = 1;
        #1;
        check_ex("");
        @(negedge clk);
    endtask

    task automatic nop();
        step(0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 0);
    endtask

    // Hold an instruction in IF/ID until it issues (bounded)
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        int n;
        n = 0;
        dut_stalls = 0;
        do begin
            step(1, op, fn, rs, rt, rd, 0);
            n++;
        end while (last_stall && n < 16);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m_ex = '0; m_busy = 0; m_ill = 0;
        check_ex("rst_");
        check("rst_stall_d", 16'(stall_d), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
                                6'h08, 6'h23, 6'h23, 6'h2B, 6'h30, 6'h3F};
    logic [5:0] fn_tab [5]  = '{6'h18, 6'h10, 6'h12, 6'h20, 6'h25};

    initial begin
        @(negedge clk);
        do_reset();
        nop();

        // Load-use: LW r5, then ADD rs=5 -> one stall, then issues
        issue(6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
        issue(6'h00, 6'h20, 5'd5, 5'd2, 5'd7);
        check("lu_stall_count", 16'(dut_stalls), 16'd1);
        check("lu_add_dst", 16'(dst_e), 16'd7);
        check("lu_add_aluop", 16'(alu_op_e), 16'd2);
        nop();

        // LW to r0 never stalls
        issue(6'h23, 6'h00, 5'd1, 5'd0, 5'd0);
        issue(6'h00, 6'h20, 5'd0, 5'd0, 5'd9);
        check("r0_stall_count", 16'(dut_stalls), 16'd0);

        // MULT then MFLO: stalled while multiplier is busy
        issue(6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
        issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd3);
        check("mflo_stall_count", 16'(dut_stalls), 16'd4);
        check("mflo_dst", 16'(dst_e), 16'd3);
        // back-to-back MULTs
        issue(6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
        issue(6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
        check("mult2_stall_count", 16'(dut_stalls), 16'd4);
        repeat (MC + 1) nop();

        // Flush on a load-use pair and on a MULT
        issue(6'h23, 6'h00, 5'd1, 5'd6, 5'd0);
        step(1, 6'h00, 6'h20, 5'd6, 5'd2, 5'd7, 1);
        check("flush_lu_rw", 16'(reg_write_e), 16'd0);
        step(1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1);
        check("flush_mult_busy", 16'(mult_busy), 16'd0);
        nop();

        // Illegal opcode: flushed is ignored, valid is sticky
        step(1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1);
        check("ill_flushed", 16'(illegal_op), 16'd0);
        step(1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 0);
        check("ill_set", 16'(illegal_op), 16'd1);
        issue(6'h08, 6'h00, 5'd1, 5'd4, 5'd0);
        nop();
        check("ill_held", 16'(illegal_op), 16'd1);

        // Reset mid-multiply
        issue(6'h00, 6'h18, 5'd1, 5'd2, 5'd0);
        nop();
        do_reset();
        check("rst_mid_mult", 16'(mult_busy), 16'd0);
        issue(6'h00, 6'h10, 5'd0, 5'd0, 5'd8);
        check("mfhi_after_rst", 16'(dut_stalls), 16'd0);

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic [5:0] op, fn;
            logic [4:0] rs, rt, rd;
            bit v, fl;
            op = (($urandom % 16) == 0) ? 6'($urandom) : op_tab[$urandom % 12];
            fn = fn_tab[$urandom % 5];
            rs = 5'($urandom % 4);
            rt = 5'($urandom % 4);
            rd = 5'($urandom % 4);
            v  = ($urandom % 8) != 0;
            fl = ($urandom % 10) == 0;
            step(v, op, fn, rs, rt, rd, fl);
            if (i % 150 == 149) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_control_stage.md
# decode_control_stage

Decode-stage control block for the 5-stage MIPS pipeline, parametrised in opcode, funct and register-address widths and in multiply latency. It decodes opcode/funct into the control bundle, detects load-use and multiply-busy hazards, and owns the ID/EX control pipeline register. Stall, flush and bubble insertion are handled in this block. It sits between the IF/ID register and the execute stage.

## Interface
- OP_BITS, 6, opcode field width
- FUNCT_BITS, 6, funct field width
- REG_ADDR_BITS, 5, register address width
- MULT_CYCLES, 4, MULT occupancy in cycles (≥1)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid_d  in  1  IF/ID holds a valid instruction
- op_code_d  in  OP_BITS  opcode; funct_d  in  FUNCT_BITS  funct
- rs_d, rt_d, rd_d  in  REG_ADDR_BITS  source/destination fields
- flush_d  in  1  decode instruction killed (taken branch/jump)
- ext_op_d, jump_d, branch_d  out  1  combinational decode-stage controls
- stall_f, stall_d  out  1  hold PC / IF/ID
- reg_write_e, mem_write_e, mem_read_e, alu_src_e  out  1  registered EX controls
- mem_to_reg_e, alu_op_e  out  2  registered EX controls
- dst_e  out  REG_ADDR_BITS  registered destination (rt, rd or 31)
- mult_busy  out  1  multiplier occupied
- illegal_op  out  1  sticky unknown-opcode flag

## Operation
Decode. Any field not listed is 0.
- ROP: reg_dst=rd, reg_write=1, alu_op=10.
  - funct MULT (0x18): reg_write=0, alu_op=11, is_mult=1.
  - funct MFHI (0x10) or MFLO (0x12): hilo_read=1.
- LW: dst=rt, alu_src=1, mem_read=1, mem_to_reg=01, reg_write=1, ext_op=1.
- SW: alu_src=1, mem_write=1, ext_op=1.
- BEQ: branch=1, alu_op=01, ext_op=1.
- ADDI: dst=rt, alu_src=1, reg_write=1, ext_op=1.
- J: jump=1.
- JAL: jump=1, dst=31, mem_to_reg=10, reg_write=1.
- LWR: dst=rd, mem_read=1, mem_to_reg=01, reg_write=1.
- Any other opcode: illegal; bundle is all-zero.
- in_valid_d=0: bundle forced to bubble (all zero).

Hazards. All terms are qualified by in_valid_d & ~flush_d.
- Load-use: mem_read_e & dst_e≠0 & (dst_e==rs_d | dst_e==rt_d). This check is conservative and does not depend on operand usage.
- Mult: mult_busy & (is_mult | hilo_read).
- stall_f = stall_d = load-use | mult.

ID/EX update each cycle:
- flush_d, stall or illegal: load bubble.
- Otherwise: load the decoded bundle and dst.

Multiply counter, width $clog2(MULT_CYCLES+1):
- Loads MULT_CYCLES when a MULT is actually captured into ID/EX.
- Otherwise decrements to 0.
- mult_busy = (count≠0).

illegal_op is set when an illegal opcode is valid, not flushed and not stalled. It clears only on reset.

## Timing
- Reset (async assert, sync-to-clk release): all *_e outputs, dst_e, counter, mult_busy and illegal_op are 0.
- Decode to EX outputs: 1 cycle.
- ext_op_d, jump_d, branch_d and stall_* are combinational in the same cycle.
- Load-use: exactly one bubble; the dependent instruction issues on the following cycle.
- MULT: captured at edge N, so mult_busy is high for edges N+1..N+MULT_CYCLES. A second MULT or MFHI/MFLO issues in the cycle mult_busy first reads 0.
- flush_d together with a hazard: stall_* are 0 and a bubble is inserted. A flushed MULT does not start the counter.
- Reset asserted mid-multiply: counter clears immediately and no stall survives reset.
- MULT_CYCLES=1: busy is high for exactly one cycle.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode localparams: ROP=0, J=2, JAL=3, BEQ=4, ADDI=8, LW=0x23, SW=0x2B, LWR=0x30;
  - funct localparams: MULT, MFHI, MFLO, ADD;
  - packed struct ctrl_t, constant CTRL_BUBBLE, and reg_dst enum {RT, RD, RA}.
- Sub-module control_decoder: purely combinational opcode/funct → ctrl_t.
- Top level: hazard logic, ID/EX register, counter and sticky flag.

## Test plan
- Reset mid-run, rst_n low asynchronously → all outputs 0 before the next clk edge.
- LW dst=5, then ADD rs=5 → stall_d=1 for 1 cycle, one bubble (reg_write_e=0), then ADD issues with dst_e=rd, alu_op_e=10.
- MULT with MULT_CYCLES=4, then MFLO → mult_busy high 4 cycles, MFLO stalled until busy falls, then issues.
- LW dst=0, then ADD rs=0 → no stall.
- flush_d=1 on a stalled LW-use pair and on a MULT → stall_*=0, bubble in EX, mult_busy stays 0.
- Opcode 0x3F valid → EX bubble and illegal_op=1 held until reset; the same opcode with flush_d=1 → illegal_op stays 0.
